// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM state type, default width.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    // Op code is {f7 bit, f3}
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b1000;
    localparam logic [3:0] OP_SLL   = 4'b0001;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b1101;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_AND   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic logic is_reserved(input logic [3:0] op);
        return (op == 4'b0011) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Bit-serial multiplier / restoring divider sharing one 2*XLEN accumulator.
// The start edge already performs the first step, so exactly XLEN steps run
// on XLEN consecutive edges; done_o then holds until the following edge.
// Multiply: acc = {high, low} of the product.  Divide: acc = {remainder, quotient}.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            is_div_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] lo_o,
    output logic [XLEN-1:0] hi_o
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q;
    logic              div_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;

    // Shift-add step: add multiplicand to the high half when the low bit is set,
    // then shift the whole accumulator (with the add carry) right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                    input logic [XLEN-1:0]   b);
        logic [XLEN:0] sum;
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
        return {sum, acc[XLEN-1:1]};
    endfunction

    // Restoring step: shift the next dividend bit into the partial remainder and
    // subtract when it fits. A zero divisor always "fits", which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                    input logic [XLEN-1:0]   b);
        logic [XLEN:0] part;
        logic [XLEN:0] diff;
        part = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = part - {1'b0, b};
        if (part >= {1'b0, b})
            return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            return {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    // Next accumulator value: first step from the fresh operands or a later step.
    always_comb begin
        acc_d = acc_q;
        if (start_i) begin
            acc_d = is_div_i ? div_step({{XLEN{1'b0}}, opa_i}, opb_i)
                             : mul_step({{XLEN{1'b0}}, opa_i}, opb_i);
        end else if (busy_q && (cnt_q != CW'(XLEN))) begin
            acc_d = div_q ? div_step(acc_q, b_q) : mul_step(acc_q, b_q);
        end
    end

    // Iteration state: accumulator, latched operand/mode, step counter, busy flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            b_q    <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            acc_q  <= acc_d;
            b_q    <= opb_i;
            div_q  <= is_div_i;
            cnt_q  <= CW'(1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == CW'(XLEN)) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CW'(XLEN));
    assign lo_o   = acc_q[XLEN-1:0];
    assign hi_o   = acc_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/alu_iter.sv
// Request/response ALU: single-cycle ops finish in one cycle, mul/div run
// bit-serially in muldiv_iter. The result is held until the consumer takes it.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] opers1_i,
    input  logic [XLEN-1:0] opers2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] salrd_o,
    output logic            err_o
);

    localparam int SW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            err_q, err_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] alu_res;
    logic            illegal;
    logic            md_start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_lo, md_hi;
    logic [SW-1:0]   shamt;

    assign shamt   = opers2_i[SW-1:0];
    assign illegal = is_reserved(op_i) || (is_muldiv(op_i) && !MULDIV_EN);

    // Single-cycle datapath straight from the request operands.
    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_ADD:  alu_res = opers1_i + opers2_i;
            OP_SUB:  alu_res = opers1_i - opers2_i;
            OP_SLL:  alu_res = opers1_i << shamt;
            OP_SRL:  alu_res = opers1_i >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(opers1_i) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opers1_i) < $signed(opers2_i))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opers1_i < opers2_i)};
            OP_XOR:  alu_res = opers1_i ^ opers2_i;
            OP_OR:   alu_res = opers1_i | opers2_i;
            OP_AND:  alu_res = opers1_i & opers2_i;
            default: alu_res = '0;
        endcase
    end

    // Control FSM: accept in IDLE, wait in CALC, hold the result in DONE.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        err_d    = err_q;
        op_d     = op_q;
        md_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    op_d = op_i;
                    if (illegal) begin
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (is_muldiv(op_i)) begin
                        md_start = 1'b1;
                        err_d    = 1'b0;
                        state_d  = S_CALC;
                    end else begin
                        res_d   = alu_res;
                        err_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (md_done) begin
                    res_d   = ((op_q == OP_MULHU) || (op_q == OP_REMU)) ? md_hi : md_lo;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            res_q   <= '0;
            err_q   <= 1'b0;
            op_q    <= OP_ADD;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            err_q   <= err_d;
            op_q    <= op_d;
        end
    end

    generate
        if (MULDIV_EN) begin : g_muldiv
            muldiv_iter #(.XLEN(XLEN)) u_muldiv (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .start_i  (md_start),
                .is_div_i ((op_i == OP_DIVU) || (op_i == OP_REMU)),
                .opa_i    (opers1_i),
                .opb_i    (opers2_i),
                .busy_o   (md_busy),
                .done_o   (md_done),
                .lo_o     (md_lo),
                .hi_o     (md_hi)
            );
        end else begin : g_no_muldiv
            assign md_busy = 1'b0;
            assign md_done = 1'b0;
            assign md_lo   = '0;
            assign md_hi   = '0;
        end
    endgenerate

    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign salrd_o = res_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter at XLEN=32 with hand-computed expectations.
module tb_alu_iter;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  op_i;
    logic [31:0] opers1_i;
    logic [31:0] opers2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] salrd_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    alu_iter #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .opers1_i (opers1_i),
        .opers2_i (opers2_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .salrd_o  (salrd_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        valid_i  = 1'b1;
        op_i     = op;
        opers1_i = a;
        opers2_i = b;
        @(posedge clk_i);
        #1;
        valid_i  = 1'b0;
        op_i     = 4'($urandom);
        opers1_i = $urandom;
        opers2_i = $urandom;
    endtask

    // Count cycles from acceptance until valid_o; note if ready_o rose meanwhile.
    task automatic wait_res(output int lat, output bit saw_rdy);
        lat     = 1;
        saw_rdy = 1'b0;
        while (!valid_o && lat < 100) begin
            if (ready_o) saw_rdy = 1'b1;
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk_i);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input bit exp_err,
                       input int exp_lat);
        int lat;
        bit saw_rdy;
        send(op, a, b);
        wait_res(lat, saw_rdy);
        check_eq({tag, "_res"}, 64'(salrd_o), 64'(exp));
        check_eq({tag, "_err"}, 64'(err_o), 64'(exp_err));
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_rdy"}, 64'(saw_rdy), 64'd0);
        consume();
    endtask

    initial begin
        int  lat;
        bit  saw_rdy;
        bit  saw_vld;
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        op_i     = 4'd0;
        opers1_i = '0;
        opers2_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_res",   64'(salrd_o), 64'd0);
        check_eq("rst_err",   64'(err_o),   64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("rst_ready", 64'(ready_o), 64'd1);

        run("add_wrap", OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1);
        run("sub",      OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
        run("slt",      OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1);
        run("sltu",     OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1);
        run("sra",      OP_SRA,   32'h8000_0000, 32'd35,        32'hF000_0000, 1'b0, 1);
        run("srl",      OP_SRL,   32'h8000_0000, 32'd35,        32'h1000_0000, 1'b0, 1);
        run("sll",      OP_SLL,   32'd1,         32'd33,        32'd2,         1'b0, 1);
        run("xor",      OP_XOR,   32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1);
        run("or",       OP_OR,    32'hF000_000F, 32'h0000_FF00, 32'hF000_FF0F, 1'b0, 1);
        run("and",      OP_AND,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
        run("mul",      OP_MUL,   32'h0001_0000, 32'h0001_0000, 32'd0,         1'b0, 33);
        run("mulhu",    OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1,         1'b0, 33);
        run("mul_dec",  OP_MUL,   32'd12345,     32'd6789,      32'd83810205,  1'b0, 33);
        run("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        run("divu",     OP_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 33);
        run("remu",     OP_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 33);
        run("divu_big", OP_DIVU,  32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 1'b0, 33);
        run("divu_z",   OP_DIVU,  32'd12345,     32'd0,         32'hFFFF_FFFF, 1'b0, 33);
        run("remu_z",   OP_REMU,  32'd100,       32'd0,         32'd100,       1'b0, 33);
        run("rsv_f",    4'b1111,  32'd9,         32'd9,         32'd0,         1'b1, 1);
        run("rsv_3",    4'b0011,  32'd9,         32'd9,         32'd0,         1'b1, 1);

        // Hold the consumer off for 5 cycles while new requests knock.
        send(OP_ADD, 32'd40, 32'd2);
        wait_res(lat, saw_rdy);
        check_eq("stall_first", 64'(salrd_o), 64'd42);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            valid_i  = 1'b1;
            op_i     = OP_SUB;
            opers1_i = 32'd7;
            opers2_i = 32'd1;
            @(posedge clk_i);
            #1;
            check_eq("stall_vld", 64'(valid_o), 64'd1);
            check_eq("stall_res", 64'(salrd_o), 64'd42);
            check_eq("stall_rdy", 64'(ready_o), 64'd0);
        end
        consume();
        check_eq("post_stall_vld", 64'(valid_o), 64'd0);
        check_eq("post_stall_rdy", 64'(ready_o), 64'd1);

        // Reset in the middle of a multiply: nothing may ever come out.
        send(OP_MUL, 32'd3, 32'd5);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_eq("abort_vld", 64'(valid_o), 64'd0);
        check_eq("abort_res", 64'(salrd_o), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_eq("abort_rdy", 64'(ready_o), 64'd1);
        saw_vld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o) saw_vld = 1'b1;
        end
        check_eq("abort_never_vld", 64'(saw_vld), 64'd0);
        run("add_after", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
